// File: rtl/prescaler_pkg.sv
// prescaler_pkg: shared types, defaults and helpers for the multi-channel
// prescaler (prescaler_channel, prescaler_multi).
// Optional feature macro: PRESCALER_DUTY_EN (programmable high time).
package prescaler_pkg;

  localparam int unsigned CNT_W_DEF          = 32;
  localparam int unsigned DEFAULT_PERIOD_DEF = 50;
  // Widest counter the helper functions handle.
  localparam int unsigned MAX_CNT_W          = 64;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } chan_state_e;

  // Channel-select width, at least one bit even for a single channel.
  function automatic int unsigned ch_width(input int unsigned channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  // High time never exceeds the period; high >= period means constant high.
  function automatic logic [MAX_CNT_W-1:0] clamp_high(
    input logic [MAX_CNT_W-1:0] period,
    input logic [MAX_CNT_W-1:0] high
  );
    return (high > period) ? period : high;
  endfunction

  // Fixed 50% duty (floor); period 1 still produces a high output.
  function automatic logic [MAX_CNT_W-1:0] half_high(input logic [MAX_CNT_W-1:0] period);
    return (period == MAX_CNT_W'(1)) ? MAX_CNT_W'(1) : (period >> 1);
  endfunction

endpackage

// File: rtl/prescaler_channel.sv
// prescaler_channel: one divider channel -- period counter, shadow period /
// high time with boundary-aligned reload, registered divided outputs.
// Ports:
//   i_clk, i_rst        clock, async active-high reset
//   i_en                run enable
//   i_wr                accepted configuration write for this channel
//   i_period, i_duty    new period / high time (i_duty used only with
//                       PRESCALER_DUTY_EN)
//   o_clk_div, o_tick   divided waveform, period-start strobe
//   o_reload_done       strobe on the edge the shadow is applied
//   o_pending           shadow waiting to be applied
module prescaler_channel
  import prescaler_pkg::*;
#(
  parameter int unsigned CNT_W          = CNT_W_DEF,
  parameter int unsigned DEFAULT_PERIOD = DEFAULT_PERIOD_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_period,
  input  logic [CNT_W-1:0] i_duty,
  output logic             o_clk_div,
  output logic             o_tick,
  output logic             o_reload_done,
  output logic             o_pending
);

  localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEFAULT_PERIOD);

  chan_state_e      r_state;
  chan_state_e      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_sh_period;
  logic [CNT_W-1:0] w_high;
  logic [CNT_W-1:0] w_sh_high;
  logic             r_pending;
  logic             r_clk_div;
  logic             r_tick;
  logic             r_reload_done;
  logic             w_apply;
  logic             w_last;
  logic             w_clk_div_nxt;
  logic             w_tick_nxt;

`ifdef PRESCALER_DUTY_EN
  localparam logic [CNT_W-1:0] RST_HIGH = CNT_W'(DEFAULT_PERIOD >> 1);

  logic [CNT_W-1:0] r_high;
  logic [CNT_W-1:0] r_sh_high;

  assign w_high    = r_high;
  assign w_sh_high = r_sh_high;

  // Programmable high time, clamped to the period at capture.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_high    <= RST_HIGH;
      r_sh_high <= RST_HIGH;
    end else begin
      if (w_apply) r_high <= r_sh_high;
      if (i_wr)    r_sh_high <= CNT_W'(clamp_high(MAX_CNT_W'(i_period), MAX_CNT_W'(i_duty)));
    end
  end
`else
  logic w_duty_unused;
  assign w_duty_unused = ^i_duty;

  // High time follows the period; no duty storage.
  assign w_high    = CNT_W'(half_high(MAX_CNT_W'(r_period)));
  assign w_sh_high = CNT_W'(half_high(MAX_CNT_W'(r_sh_period)));
`endif

  assign w_last = (r_cnt == (r_period - CNT_W'(1)));

  // State register plus counter, period, shadow and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_period      <= RST_PERIOD;
      r_sh_period   <= RST_PERIOD;
      r_pending     <= 1'b0;
      r_clk_div     <= 1'b0;
      r_tick        <= 1'b0;
      r_reload_done <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_clk_div     <= w_clk_div_nxt;
      r_tick        <= w_tick_nxt;
      r_reload_done <= w_apply;
      if (w_apply) begin
        r_period  <= r_sh_period;
        r_pending <= 1'b0;
      end
      // A write is only accepted while nothing is pending, so it never
      // collides with a reload on the same edge.
      if (i_wr) begin
        r_sh_period <= i_period;
        r_pending   <= 1'b1;
      end
    end
  end

  // Next state, next count and reload decision.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_apply     = 1'b0;
    if (r_state == IDLE) begin
      w_cnt_nxt = '0;
      // An idle channel applies its shadow first and starts on a later edge.
      if (r_pending) begin
        w_apply = 1'b1;
      end else if (i_en && (r_period != '0)) begin
        w_state_nxt = RUN;
      end
    end else begin
      if (!i_en || (r_period == '0)) begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end else if (w_last) begin
        w_cnt_nxt = '0;
        if (r_pending) begin
          w_apply = 1'b1;
          if (r_sh_period == '0) w_state_nxt = IDLE;
        end
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  // Next registered outputs; a reloading wrap already uses the new high time.
  always_comb begin
    w_tick_nxt    = 1'b0;
    w_clk_div_nxt = 1'b0;
    if (w_state_nxt == RUN) begin
      w_tick_nxt    = (w_cnt_nxt == '0);
      w_clk_div_nxt = (w_cnt_nxt < (w_apply ? w_sh_high : w_high));
    end
  end

  assign o_clk_div     = r_clk_div;
  assign o_tick        = r_tick;
  assign o_reload_done = r_reload_done;
  assign o_pending     = r_pending;

endmodule

// File: rtl/prescaler_multi.sv
// prescaler_multi: CHANNELS independent programmable clock prescalers on a
// single clock, with a shared valid/ready configuration write port.
// Optional feature macro: PRESCALER_DUTY_EN (cfg_duty sets the high time;
// otherwise high time is period/2).
// Ports:
//   src_clk, rst            clock, async active-high reset
//   en[CHANNELS]            per-channel run enable
//   cfg_valid / cfg_ready   configuration write handshake
//   cfg_ch                  target channel (out-of-range writes are dropped)
//   cfg_period, cfg_duty    new period / high time
//   clk_div, tick           divided waveform, period-start strobe (registered)
//   reload_done             strobe when a channel applies its new setting
module prescaler_multi
  import prescaler_pkg::*;
#(
  parameter int unsigned CHANNELS       = 4,
  parameter int unsigned CNT_W          = CNT_W_DEF,
  parameter int unsigned DEFAULT_PERIOD = DEFAULT_PERIOD_DEF
) (
  input  logic                          src_clk,
  input  logic                          rst,
  input  logic [CHANNELS-1:0]           en,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [ch_width(CHANNELS)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]              cfg_period,
  input  logic [CNT_W-1:0]              cfg_duty,
  output logic [CHANNELS-1:0]           clk_div,
  output logic [CHANNELS-1:0]           tick,
  output logic [CHANNELS-1:0]           reload_done
);

  localparam int unsigned CH_W = ch_width(CHANNELS);

  logic [CHANNELS-1:0] w_wr;
  logic [CHANNELS-1:0] w_pending;

  // Ready unless the addressed channel still holds an unapplied write.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if ((cfg_ch == CH_W'(i)) && w_pending[i]) cfg_ready = 1'b0;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign w_wr[g] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));

    prescaler_channel #(
      .CNT_W          (CNT_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .i_clk         (src_clk),
      .i_rst         (rst),
      .i_en          (en[g]),
      .i_wr          (w_wr[g]),
      .i_period      (cfg_period),
      .i_duty        (cfg_duty),
      .o_clk_div     (clk_div[g]),
      .o_tick        (tick[g]),
      .o_reload_done (reload_done[g]),
      .o_pending     (w_pending[g])
    );
  end

endmodule

// File: tb/tb_prescaler_multi.sv
// Testbench for prescaler_multi: directed scenarios plus randomized traffic,
// all checked against a cycle-level behavioural model of each channel.
`timescale 1ns/1ps
module tb_prescaler_multi;

  localparam int CH = 4;

  logic          src_clk = 1'b0;
  logic          rst;
  logic [CH-1:0] en;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [1:0]    cfg_ch;
  logic [31:0]   cfg_period;
  logic [31:0]   cfg_duty;
  logic [CH-1:0] clk_div;
  logic [CH-1:0] tick;
  logic [CH-1:0] reload_done;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: a channel is running or not, and sits at some phase
  // within its current period.
  bit            m_run   [CH];
  bit            m_pend  [CH];
  int            m_phase [CH];
  int            m_period[CH];
  int            m_high  [CH];
  int            m_shp   [CH];
  int            m_shh   [CH];
  logic [CH-1:0] e_tick;
  logic [CH-1:0] e_div;
  logic [CH-1:0] e_rel;

  prescaler_multi #(.CHANNELS(CH), .CNT_W(32), .DEFAULT_PERIOD(50)) dut (
    .src_clk     (src_clk),
    .rst         (rst),
    .en          (en),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_period  (cfg_period),
    .cfg_duty    (cfg_duty),
    .clk_div     (clk_div),
    .tick        (tick),
    .reload_done (reload_done)
  );

  always #5 src_clk = ~src_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_run[c] = 0; m_pend[c] = 0; m_phase[c] = 0;
      m_period[c] = 50; m_high[c] = 25; m_shp[c] = 50; m_shh[c] = 25;
    end
    e_tick = '0; e_div = '0; e_rel = '0;
  endtask

  // Advance the model by one clock edge using the inputs presented to the DUT.
  task automatic model_edge();
    int ch;
    bit acc;
    ch  = int'(cfg_ch);
    acc = cfg_valid && !m_pend[ch];
    for (int c = 0; c < CH; c++) begin
      e_rel[c] = 1'b0;
      if (!m_run[c]) begin
        if (m_pend[c]) begin
          m_period[c] = m_shp[c]; m_high[c] = m_shh[c]; m_pend[c] = 0; e_rel[c] = 1'b1;
        end else if (en[c] && m_period[c] != 0) begin
          m_run[c] = 1; m_phase[c] = 0;
        end
      end else if (!en[c] || m_period[c] == 0) begin
        m_run[c] = 0;
      end else begin
        m_phase[c] = m_phase[c] + 1;
        if (m_phase[c] >= m_period[c]) begin
          m_phase[c] = 0;
          if (m_pend[c]) begin
            m_period[c] = m_shp[c]; m_high[c] = m_shh[c]; m_pend[c] = 0; e_rel[c] = 1'b1;
            if (m_period[c] == 0) m_run[c] = 0;
          end
        end
      end
    end
    if (acc) begin
      m_shp[ch] = int'(cfg_period);
`ifdef PRESCALER_DUTY_EN
      m_shh[ch] = (int'(cfg_duty) > m_shp[ch]) ? m_shp[ch] : int'(cfg_duty);
`else
      m_shh[ch] = (m_shp[ch] == 1) ? 1 : m_shp[ch] / 2;
`endif
      m_pend[ch] = 1;
    end
    for (int c = 0; c < CH; c++) begin
      e_tick[c] = m_run[c] && (m_phase[c] == 0);
      e_div[c]  = m_run[c] && (m_phase[c] < m_high[c]);
    end
  endtask

  // One clock: model follows the edge, outputs are sampled at the falling edge.
  task automatic step();
    @(posedge src_clk);
    model_edge();
    @(negedge src_clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_duty = '0;
    model_reset();
    repeat (2) @(negedge src_clk);
    for (int c = 0; c < CH; c++) begin
      cfg_ch = 2'(c);
      #1;
      n_tests++;
      if (cfg_ready !== 1'b1) begin
        n_fail++; $display("FAIL reset_ready ch%0d: cfg_ready=%b expected 1", c, cfg_ready);
      end
    end
    n_tests++;
    if (tick !== '0 || clk_div !== '0 || reload_done !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: tick=%b clk_div=%b reload_done=%b expected 0000", tick, clk_div, reload_done);
    end
    @(negedge src_clk);
    rst = 1'b0;
    step();
    n_tests++;
    if (tick !== '0 || clk_div !== '0 || reload_done !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset: tick=%b clk_div=%b reload_done=%b expected 0000", tick, clk_div, reload_done);
    end
  endtask

  task automatic test_default_period();
    int ticks = 0;
    int highs = 0;
    en[0] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      n_tests++;
      if (tick !== e_tick || clk_div !== e_div || reload_done !== e_rel) begin
        n_fail++;
        $display("FAIL default_period cyc%0d: tick=%b clk_div=%b rel=%b expected %b %b %b",
                 i, tick, clk_div, reload_done, e_tick, e_div, e_rel);
      end
      if (tick[0]) ticks++;
      if (clk_div[0]) highs++;
    end
    n_tests++;
    if (ticks != 2 || highs != 50) begin
      n_fail++; $display("FAIL default_counts: ticks=%0d highs=%0d expected 2 50", ticks, highs);
    end
  endtask

  task automatic test_reload_running();
    int rel_at = -1;
    int guard  = 0;
    en[1] = 1'b0;
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_period = 32'd10; cfg_duty = 32'd5;
    step();
    cfg_valid = 1'b0;
    n_tests++;
    if (reload_done[1] !== 1'b0) begin
      n_fail++; $display("FAIL idle_reload_early: reload_done[1]=%b expected 0", reload_done[1]);
    end
    step();
    n_tests++;
    if (reload_done[1] !== 1'b1) begin
      n_fail++; $display("FAIL idle_reload: reload_done[1]=%b expected 1", reload_done[1]);
    end
    en[1] = 1'b1;
    step();
    while (!(m_run[1] && m_phase[1] == 3) && guard < 20) begin
      step();
      guard++;
    end
    n_tests++;
    if (guard >= 20 || tick !== e_tick || clk_div !== e_div) begin
      n_fail++; $display("FAIL reach_cnt3: tick=%b clk_div=%b expected %b %b (guard %0d)",
                         tick, clk_div, e_tick, e_div, guard);
    end
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_period = 32'd4; cfg_duty = 32'd2;
    #1;
    n_tests++;
    if (cfg_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_before_write: cfg_ready=%b expected 1", cfg_ready);
    end
    step();
    cfg_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      #1;
      if (rel_at < 0) begin
        n_tests++;
        if (cfg_ready !== 1'b0) begin
          n_fail++; $display("FAIL ready_while_pending k%0d: cfg_ready=%b expected 0", k, cfg_ready);
        end
      end
      step();
      n_tests++;
      if (tick !== e_tick || clk_div !== e_div || reload_done !== e_rel) begin
        n_fail++;
        $display("FAIL reload_running k%0d: tick=%b clk_div=%b rel=%b expected %b %b %b",
                 k, tick, clk_div, reload_done, e_tick, e_div, e_rel);
      end
      if (reload_done[1] === 1'b1 && rel_at < 0) begin
        rel_at = k;
        n_tests++;
        if (tick[1] !== 1'b1) begin
          n_fail++; $display("FAIL reload_with_tick: tick[1]=%b expected 1", tick[1]);
        end
      end
    end
    n_tests++;
    if (rel_at != 6) begin
      n_fail++; $display("FAIL reload_timing: reload after %0d edges expected 6", rel_at);
    end
  endtask

  task automatic test_period_edges();
    en[2] = 1'b0;
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_period = 32'd1; cfg_duty = 32'd1;
    step();
    cfg_valid = 1'b0;
    step();
    en[2] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_tests++;
      if (tick[2] !== 1'b1 || clk_div[2] !== 1'b1 || tick !== e_tick || clk_div !== e_div) begin
        n_fail++; $display("FAIL period1 cyc%0d: tick=%b clk_div=%b expected %b %b", i, tick, clk_div, e_tick, e_div);
      end
    end
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_period = 32'd0; cfg_duty = 32'd0;
    step();
    cfg_valid = 1'b0;
    step();
    n_tests++;
    if (reload_done[2] !== 1'b1 || tick[2] !== 1'b0 || clk_div[2] !== 1'b0) begin
      n_fail++; $display("FAIL period0_apply: rel=%b tick=%b div=%b expected 1 0 0",
                         reload_done[2], tick[2], clk_div[2]);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      n_tests++;
      if (tick[2] !== 1'b0 || clk_div[2] !== 1'b0 || tick !== e_tick || clk_div !== e_div) begin
        n_fail++; $display("FAIL period0 cyc%0d: tick=%b clk_div=%b expected %b %b", i, tick, clk_div, e_tick, e_div);
      end
    end
  endtask

  task automatic test_en_drop();
    en[3] = 1'b1;
    for (int i = 0; i < 12; i++) step();
    n_tests++;
    if (clk_div[3] !== 1'b1 || tick !== e_tick || clk_div !== e_div) begin
      n_fail++; $display("FAIL en_run: clk_div=%b tick=%b expected %b %b", clk_div, tick, e_div, e_tick);
    end
    en[3] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_tests++;
      if (tick[3] !== 1'b0 || clk_div[3] !== 1'b0) begin
        n_fail++; $display("FAIL en_low cyc%0d: tick[3]=%b clk_div[3]=%b expected 0 0", i, tick[3], clk_div[3]);
      end
    end
    en[3] = 1'b1;
    step();
    n_tests++;
    if (tick[3] !== 1'b1 || clk_div[3] !== 1'b1 || tick !== e_tick || clk_div !== e_div) begin
      n_fail++; $display("FAIL en_restart: tick=%b clk_div=%b expected %b %b", tick, clk_div, e_tick, e_div);
    end
  endtask

`ifdef PRESCALER_DUTY_EN
  task automatic test_duty();
    int duty_tab[3] = '{3, 9, 0};
    int high_tab[3] = '{6, 16, 0};
    for (int t = 0; t < 3; t++) begin
      int highs = 0;
      en[0] = 1'b0;
      step();
      cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_period = 32'd8; cfg_duty = 32'(duty_tab[t]);
      step();
      cfg_valid = 1'b0;
      step();
      en[0] = 1'b1;
      for (int i = 0; i < 16; i++) begin
        step();
        if (clk_div[0]) highs++;
      end
      n_tests++;
      if (highs != high_tab[t] || clk_div !== e_div) begin
        n_fail++; $display("FAIL duty%0d: highs=%0d expected %0d", duty_tab[t], highs, high_tab[t]);
      end
    end
  endtask
`endif

  task automatic test_random();
    int idx;
    en = 4'b1111;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(15) == 0) begin
        idx = int'($urandom_range(CH - 1));
        en[idx] = ~en[idx];
      end
      cfg_valid  = ($urandom_range(3) == 0);
      cfg_ch     = 2'($urandom_range(CH - 1));
      cfg_period = ($urandom_range(7) == 0) ? 32'd0 : 32'($urandom_range(12, 1));
      cfg_duty   = 32'($urandom_range(15));
      #1;
      n_tests++;
      if (cfg_ready !== !m_pend[int'(cfg_ch)]) begin
        n_fail++; $display("FAIL rand_ready cyc%0d ch%0d: cfg_ready=%b expected %b",
                           i, cfg_ch, cfg_ready, !m_pend[int'(cfg_ch)]);
      end
      step();
      n_tests++;
      if (tick !== e_tick || clk_div !== e_div || reload_done !== e_rel) begin
        n_fail++;
        $display("FAIL rand cyc%0d: tick=%b clk_div=%b rel=%b expected %b %b %b",
                 i, tick, clk_div, reload_done, e_tick, e_div, e_rel);
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int ticks = 0;
    cfg_valid = 1'b0;
    en = 4'b0010;
    rst = 1'b1;
    model_reset();
    @(negedge src_clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_period = 32'd7; cfg_duty = 32'd3;
    step();
    cfg_valid = 1'b0;
    step();
    step();
    n_tests++;
    if (clk_div[1] !== 1'b1 || clk_div !== e_div) begin
      n_fail++; $display("FAIL pre_reset: clk_div=%b expected %b", clk_div, e_div);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if (tick !== '0 || clk_div !== '0 || reload_done !== '0 || cfg_ready !== 1'b1) begin
      n_fail++; $display("FAIL async_reset: tick=%b clk_div=%b rel=%b ready=%b expected 0000 0000 0000 1",
                         tick, clk_div, reload_done, cfg_ready);
    end
    @(negedge src_clk);
    rst = 1'b0;
    for (int i = 0; i < 110; i++) begin
      step();
      n_tests++;
      if (reload_done !== '0 || tick !== e_tick || clk_div !== e_div) begin
        n_fail++;
        $display("FAIL after_reset cyc%0d: tick=%b clk_div=%b rel=%b expected %b %b 0000",
                 i, tick, clk_div, reload_done, e_tick, e_div);
      end
      if (tick[1]) ticks++;
    end
    n_tests++;
    if (ticks != 3) begin
      n_fail++; $display("FAIL after_reset_period: ticks=%0d expected 3", ticks);
    end
  endtask

  initial begin
    test_reset();
    test_default_period();
    test_reload_running();
    test_period_edges();
    test_en_drop();
`ifdef PRESCALER_DUTY_EN
    test_duty();
`endif
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prescaler_multi.md
# prescaler_multi

Multi-channel programmable clock prescaler: each of `CHANNELS` independent channels divides `src_clk` by a run-time period count and produces a divided clock-enable waveform plus a one-cycle period tick. Period updates go through a shadow register and take effect only on a period boundary, so divided outputs never glitch. Sits between the host configuration logic and the sample-rate / DDS stages of the sine generator, replacing per-stage single prescalers.

## Interface
- `CHANNELS`, 4: number of independent divider channels (1..16).
- `CNT_W`, 32: width of period/duty counters.
- `DEFAULT_PERIOD`, 50: period loaded into every channel at reset.
- `src_clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `en` in `CHANNELS`: per-channel run enable.
- `cfg_valid` in 1: configuration write request.
- `cfg_ready` out 1: write accepted when `cfg_valid && cfg_ready`.
- `cfg_ch` in `$clog2(CHANNELS)` (min 1): target channel.
- `cfg_period` in `CNT_W`: new period in `src_clk` cycles.
- `cfg_duty` in `CNT_W`: new high time in cycles (used only with `PRESCALER_DUTY_EN`).
- `clk_div` out `CHANNELS`: divided waveform, registered.
- `tick` out `CHANNELS`: one-cycle strobe at first cycle of each period, registered.
- `reload_done` out `CHANNELS`: one-cycle strobe when shadow period is applied.

## Operation
- Per channel: active `period`, `high`, counter `cnt` (0..period-1), shadow `sh_period`/`sh_high`, flag `pending`.
- States per channel: IDLE (`en`=0 or period=0) and RUN.
- IDLE -> RUN when `en`=1 and period≠0: `cnt`=0, `tick`=1, `clk_div`=(high>0).
- RUN: `cnt` increments; at `cnt==period-1` wraps to 0 with `tick`=1. `clk_div`=1 while `cnt<high`.
- RUN -> IDLE when `en`=0: next edge `cnt`=0, `clk_div`=0, `tick`=0. Period 0 forces IDLE regardless of `en`.
- Config write: captures `cfg_period`, high time into shadow of `cfg_ch`, sets `pending`. `cfg_ready` = !`pending[cfg_ch]`.
- Reload: pending channel in RUN applies shadow on the wrap edge (new period starts with the tick); in IDLE applies on the next edge. `reload_done` pulses that edge, `pending` clears.
- High time clamp: high ≥ period -> `clk_div` constantly 1 in RUN; high=0 -> constantly 0.
- Period 1: `tick` and `clk_div` (high clamped to 1) high every RUN cycle.
- `cfg_ch` ≥ `CHANNELS`: write accepted (`cfg_ready`=1), discarded, no `reload_done`.
- Channels fully independent; simultaneous wraps/reloads on different channels all occur.

## Timing
- Reset: `cnt`=0, period=`DEFAULT_PERIOD`, high=`DEFAULT_PERIOD>>1`, `pending`=0, `clk_div`=0, `tick`=0, `reload_done`=0, `cfg_ready`=1.
- `en` rising sampled at edge k: `tick` high in cycle after edge k; subsequent ticks every `period` cycles.
- `en` falling sampled at edge k: outputs low after edge k.
- Write accepted at edge k on idle channel: `reload_done` after edge k+1; new waveform starts after k+2 once enabled.
- Write on running channel: no change before current period ends; `reload_done` and `tick` coincide.
- Reset mid-period: outputs drop asynchronously; pending writes lost.

## Configuration
- `PRESCALER_DUTY_EN` defined: high time = `cfg_duty` (clamped as above); `DEFAULT_PERIOD>>1` at reset.
- Not defined: `cfg_duty` ignored, high time = `period>>1` (floor), period 1 -> high 1; duty registers removed.

## Structure
- Shared package `prescaler_pkg`: `CNT_W` default, channel state enum (IDLE, RUN), `DEFAULT_PERIOD`, high-time clamp function.
- Sub-module `prescaler_channel`: one channel (counter, shadow, reload, outputs); top instantiates `CHANNELS` copies and decodes `cfg_ch`/`cfg_ready`.

## Test plan
- Reset, `en[0]`=1, default period 50 -> `tick[0]` every 50 cycles, `clk_div[0]` high 25 / low 25.
- Ch1 running period 10; write period 4 at cnt=3 -> unchanged until wrap, `reload_done[1]`+`tick[1]` together, then period 4; `cfg_ready` low for ch1 meanwhile.
- Period 1 and period 0 on ch2 -> `tick`/`clk_div` high every cycle; then stalled low with `en`=1.
- `PRESCALER_DUTY_EN`: period 8 duty 3 -> 3 high / 5 low; duty 9 -> constant high; duty 0 -> constant low.
- Drop `en[3]` mid-period, reassert 5 cycles later -> outputs low next edge, restart at cnt 0 with `tick`.
- Assert `rst` mid-operation with pending write -> all outputs 0 immediately, period back to 50, no `reload_done`.
